// File: rtl/cp0_pkg.sv
//------------------------------------------------------------------------------
// Module      : cp0_pkg
// Description : Shared CP0 constants: register numbers, field positions,
//               exception codes, PRId value and exception handler address.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cp0_pkg;

    // Register numbers
    localparam logic [4:0]  C_REG_SR    = 5'd12;
    localparam logic [4:0]  C_REG_CAUSE = 5'd13;
    localparam logic [4:0]  C_REG_EPC   = 5'd14;
    localparam logic [4:0]  C_REG_PRID  = 5'd15;

    // SR field positions
    localparam int C_SR_IM_HI  = 15;
    localparam int C_SR_IM_LO  = 10;
    localparam int C_SR_EXL    = 1;
    localparam int C_SR_IE     = 0;

    // Cause field positions
    localparam int C_CAUSE_BD     = 31;
    localparam int C_CAUSE_IP_HI  = 15;
    localparam int C_CAUSE_IP_LO  = 10;
    localparam int C_CAUSE_EXC_HI = 6;
    localparam int C_CAUSE_EXC_LO = 2;

    // ExcCode values
    localparam logic [4:0]  C_EXC_INT     = 5'd0;
    localparam logic [4:0]  C_EXC_ADEL    = 5'd4;
    localparam logic [4:0]  C_EXC_ADES    = 5'd5;
    localparam logic [4:0]  C_EXC_SYSCALL = 5'd8;
    localparam logic [4:0]  C_EXC_RI      = 5'd10;
    localparam logic [4:0]  C_EXC_OV      = 5'd12;

    localparam logic [31:0] C_PRID_VALUE   = 32'h4D49_5053;
    localparam logic [31:0] C_HANDLER_ADDR = 32'h0000_4180;

endpackage

`default_nettype wire

// File: rtl/cp0.sv
//------------------------------------------------------------------------------
// Module      : cp0
// Description : Coprocessor 0: SR/Cause/EPC/PRId, interrupt and exception
//               request generation, mtc0/mfc0 and eret support.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cp0
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] CP0Out,
    output logic [31:0] EPCOut,
    output logic        Req
);

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_wr;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic [31:0] w_epc_victim;

    assign w_int_req = r_ie & ~r_exl & (|(HWInt & r_im));
    assign w_exc_req = ~r_exl & (ExcCodeIn != 5'd0);
    assign Req       = w_int_req | w_exc_req;
    assign w_wr      = en & ~Req;

    // Victim in a delay slot restarts at the branch, one word earlier
    assign w_epc_victim = {VPC[31:2], 2'b00} - (BDIn ? 32'd4 : 32'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_im       <= '0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip       <= '0;
            r_exc_code <= '0;
            r_epc      <= '0;
        end else begin
            r_ip <= HWInt;
            if (Req) begin
                r_exl      <= 1'b1;
                r_bd       <= BDIn;
                r_exc_code <= w_int_req ? C_EXC_INT : ExcCodeIn;
                r_epc      <= w_epc_victim;
            end else begin
                if (w_wr && CP0Add == C_REG_SR) begin
                    r_im  <= CP0In[C_SR_IM_HI:C_SR_IM_LO];
                    r_exl <= CP0In[C_SR_EXL];
                    r_ie  <= CP0In[C_SR_IE];
                end else if (EXLClr) begin
                    r_exl <= 1'b0;
                end
                if (w_wr && CP0Add == C_REG_EPC) begin
                    r_epc <= CP0In;
                end
            end
        end
    end

    always_comb begin
        w_sr                          = '0;
        w_sr[C_SR_IM_HI:C_SR_IM_LO]   = r_im;
        w_sr[C_SR_EXL]                = r_exl;
        w_sr[C_SR_IE]                 = r_ie;

        w_cause                                 = '0;
        w_cause[C_CAUSE_BD]                     = r_bd;
        w_cause[C_CAUSE_IP_HI:C_CAUSE_IP_LO]    = r_ip;
        w_cause[C_CAUSE_EXC_HI:C_CAUSE_EXC_LO]  = r_exc_code;
    end

    always_comb begin
        CP0Out = '0;
        case (CP0Add)
            C_REG_SR:    CP0Out = w_sr;
            C_REG_CAUSE: CP0Out = w_cause;
            C_REG_EPC:   CP0Out = r_epc;
            C_REG_PRID:  CP0Out = C_PRID_VALUE;
            default:     CP0Out = '0;
        endcase
    end

    // Forward a same-cycle EPC write to an eret that immediately follows
    assign EPCOut = (en && CP0Add == C_REG_EPC) ? CP0In : r_epc;

endmodule

`default_nettype wire
